// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box/rcon tables and byte helpers used by the
// iterative encryption core and its round function.
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_t;

    // Entry 0x00 sits in the most significant byte, so lookups index from the top.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[8'd255 - b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rounds outside 1..10 only occur while the chain idles; they get no rcon.
    function automatic logic [7:0] get_rcon(input logic [3:0] round);
        logic [3:0] idx;
        idx = round - 4'd1;
        if (round >= 4'd1 && round <= 4'd10) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block-in / ciphertext-out handshake bundle of the iterative AES core.
// master = host source/sink side, slave = the core.
interface aes_iter_core_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    modport master (
        output in_valid, key, plaintext, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, key, plaintext, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );

endinterface

// File: rtl/aes_round.sv
// One combinational AES-128 encryption round with its key-expansion step:
// SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rkey_in,
    input  logic [3:0]   round_idx,
    input  logic         last_round,
    output logic [127:0] state_out,
    output logic [127:0] rkey_out
);

    logic [7:0]  sb [16];
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];
    logic [31:0] w  [4];
    logic [31:0] nw [4];
    logic [31:0] temp;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w[i] = rkey_in[127 - 32*i -: 32];
        end
        temp = {sub_byte(w[3][23:16]), sub_byte(w[3][15:8]),
                sub_byte(w[3][7:0]),   sub_byte(w[3][31:24])}
               ^ {get_rcon(round_idx), 24'h000000};
        nw[0] = w[0] ^ temp;
        nw[1] = w[1] ^ nw[0];
        nw[2] = w[2] ^ nw[1];
        nw[3] = w[3] ^ nw[2];
        rkey_out = {nw[0], nw[1], nw[2], nw[3]};
    end

    // Bytes are column-major: index = row + 4*column.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sub_byte(state_in[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ rkey_out[127 - 8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core: FSM, round counter and handshakes around a
// chain of ROUNDS_PER_CYCLE aes_round stages. Optional macro: AES_ZEROISE_EN.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic           clk,
    input  logic           rst,
    aes_iter_core_if.slave bus
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
            $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
    endgenerate

    localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] LAST = 4'(AES_ROUNDS);

    fsm_state_t   fsm_q;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_next;
    logic [127:0] state_q;
    logic [127:0] rkey_q;
    logic [127:0] ct_q;
    logic         accept;

    logic [127:0] chain_state [ROUNDS_PER_CYCLE + 1];
    logic [127:0] chain_key   [ROUNDS_PER_CYCLE + 1];

    assign chain_state[0] = state_q;
    assign chain_key[0]   = rkey_q;

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        logic [3:0] idx;
        assign idx = cnt_q + 4'(i + 1);
        aes_round u_round (
            .state_in   (chain_state[i]),
            .rkey_in    (chain_key[i]),
            .round_idx  (idx),
            .last_round (idx == LAST),
            .state_out  (chain_state[i + 1]),
            .rkey_out   (chain_key[i + 1])
        );
    end

    assign cnt_next      = cnt_q + STEP;
    assign bus.in_ready  = rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready));
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.busy      = (fsm_q == RUN);
    assign accept        = bus.in_valid && bus.in_ready;

`ifdef AES_ZEROISE_EN
    assign bus.ciphertext = (fsm_q == DONE) ? ct_q : '0;
`else
    assign bus.ciphertext = ct_q;
`endif

    // An accept in DONE implies out_ready, so the load also completes the drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            rkey_q  <= '0;
            ct_q    <= '0;
        end else if (accept) begin
            fsm_q   <= RUN;
            cnt_q   <= '0;
            state_q <= bus.plaintext ^ bus.key;
            rkey_q  <= bus.key;
        end else begin
            case (fsm_q)
                RUN: begin
                    state_q <= chain_state[ROUNDS_PER_CYCLE];
                    rkey_q  <= chain_key[ROUNDS_PER_CYCLE];
                    cnt_q   <= cnt_next;
                    if (cnt_next == LAST) begin
                        fsm_q <= DONE;
                        ct_q  <= chain_state[ROUNDS_PER_CYCLE];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm_q <= IDLE;
`ifdef AES_ZEROISE_EN
                        ct_q    <= '0;
                        state_q <= '0;
                        rkey_q  <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: FIPS-197 vectors, backpressure, streaming
// and reset abort, with random blocks checked against a byte-level AES model.
module tb_aes_iter_core;

    localparam int LAT = 10;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] ct;
        int           acc_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_out = 0;
    sb_t  sb_q [$];
    logic [7:0] ref_sbox [256];

    aes_iter_core_if bus ();
    aes_iter_core_if bus2 ();
    aes_iter_core_if bus5 ();
    aes_iter_core_if bus10 ();

    aes_iter_core #(.ROUNDS_PER_CYCLE(1))  dut   (.clk(clk), .rst(rst), .bus(bus));
    aes_iter_core #(.ROUNDS_PER_CYCLE(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
    aes_iter_core #(.ROUNDS_PER_CYCLE(5))  dut5  (.clk(clk), .rst(rst), .bus(bus5));
    aes_iter_core #(.ROUNDS_PER_CYCLE(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine map, not a table copy.
    function automatic void build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int u = 1; u < 256; u++) begin
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            end
            s = inv;
            for (int r = 1; r < 5; r++) s = s ^ ((inv << r) | (inv >> (8 - r)));
            ref_sbox[v] = s ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   rk [176];
        logic [7:0]   s  [16];
        logic [7:0]   t  [16];
        logic [7:0]   tw [4];
        logic [7:0]   t0;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res = '0;
        for (int i = 0; i < 16; i++) rk[i] = k[127 - 8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = rk[i - 4 + j];
            if (i % 16 == 0) begin
                t0    = tw[0];
                tw[0] = ref_sbox[tw[1]] ^ rc;
                tw[1] = ref_sbox[tw[2]];
                tw[2] = ref_sbox[tw[3]];
                tw[3] = ref_sbox[t0];
                rc    = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) rk[i + j] = rk[i - 16 + j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c + w] = t[4*((c + w) % 4) + w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int w = 0; w < 4; w++) t[w] = s[4*c + w];
                    for (int w = 0; w < 4; w++)
                        s[4*c + w] = gmul(t[w], 8'h02) ^ gmul(t[(w + 1) % 4], 8'h03)
                                     ^ t[(w + 2) % 4] ^ t[(w + 3) % 4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Offers one block; the expected result is queued at the negedge before the accept edge.
    task automatic apply_stimulus(input logic [127:0] k, input logic [127:0] p,
                                  input logic [127:0] e, input logic raise_ready, output int acc);
        @(posedge clk); #1;
        bus.key       = k;
        bus.plaintext = p;
        bus.in_valid  = 1'b1;
        if (raise_ready) bus.out_ready = 1'b1;
        acc = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = cyc + 1;
                sb_q.push_back('{ct: e, acc_cyc: acc});
                n_push++;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) check_output("accept_timeout", {127'd0, bus.in_ready}, 128'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.key       = rand128();
        bus.plaintext = rand128();
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !bus.out_valid) return;
        end
        check_output("drain_timeout", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic run_aux();
        int lat2 = -1;
        int lat5 = -1;
        int lat10 = -1;
        logic [127:0] ct2 = '0;
        logic [127:0] ct5 = '0;
        logic [127:0] ct10 = '0;
        @(posedge clk); #1;
        bus2.key = B_KEY;  bus2.plaintext = B_PT;  bus2.in_valid = 1'b1;  bus2.out_ready = 1'b1;
        bus5.key = B_KEY;  bus5.plaintext = B_PT;  bus5.in_valid = 1'b1;  bus5.out_ready = 1'b1;
        bus10.key = B_KEY; bus10.plaintext = B_PT; bus10.in_valid = 1'b1; bus10.out_ready = 1'b1;
        @(negedge clk);
        check_output("rpc2_in_ready", {127'd0, bus2.in_ready}, 128'd1);
        check_output("rpc5_in_ready", {127'd0, bus5.in_ready}, 128'd1);
        check_output("rpc10_in_ready", {127'd0, bus10.in_ready}, 128'd1);
        @(posedge clk); #1;
        bus2.in_valid = 1'b0; bus5.in_valid = 1'b0; bus10.in_valid = 1'b0;
        bus2.key = rand128(); bus5.key = rand128(); bus10.key = rand128();
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus2.out_valid && lat2 < 0)   begin lat2 = n - 1;  ct2 = bus2.ciphertext;   end
            if (bus5.out_valid && lat5 < 0)   begin lat5 = n - 1;  ct5 = bus5.ciphertext;   end
            if (bus10.out_valid && lat10 < 0) begin lat10 = n - 1; ct10 = bus10.ciphertext; end
        end
        check_output("rpc2_latency", 128'(lat2), 128'd5);
        check_output("rpc5_latency", 128'(lat5), 128'd2);
        check_output("rpc10_latency", 128'(lat10), 128'd1);
        check_output("rpc2_ciphertext", ct2, B_CT);
        check_output("rpc5_ciphertext", ct5, B_CT);
        check_output("rpc10_ciphertext", ct10, B_CT);
    endtask

    initial begin : monitor
        bit  pending = 1'b1;
        sb_t item;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    check_output("spurious_output", {127'd0, bus.out_valid}, 128'd0);
                end else begin
                    if (pending) begin
                        check_output("latency", 128'(cyc - sb_q[0].acc_cyc), 128'(LAT));
                        pending = 1'b0;
                    end
                    if (bus.out_ready) begin
                        item = sb_q.pop_front();
                        check_output("ciphertext", bus.ciphertext, item.ct);
                        n_out++;
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] e;
        int acc;
        int prev_acc;
        bus.in_valid = 1'b0;   bus.key = '0;   bus.plaintext = '0;   bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;  bus2.key = '0;  bus2.plaintext = '0;  bus2.out_ready = 1'b0;
        bus5.in_valid = 1'b0;  bus5.key = '0;  bus5.plaintext = '0;  bus5.out_ready = 1'b0;
        bus10.in_valid = 1'b0; bus10.key = '0; bus10.plaintext = '0; bus10.out_ready = 1'b0;
        build_sbox();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        check_output("reset_in_ready", {127'd0, bus.in_ready}, 128'd0);
        check_output("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check_output("reset_ciphertext", bus.ciphertext, 128'd0);
        check_output("reset_busy", {127'd0, bus.busy}, 128'd0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // FIPS-197 C.1 on the one-round-per-clock core
        bus.out_ready = 1'b1;
        apply_stimulus(C1_KEY, C1_PT, C1_CT, 1'b0, acc);
        wait_drain(40);
        check_output("post_drain_busy", {127'd0, bus.busy}, 128'd0);
        check_output("post_drain_in_ready", {127'd0, bus.in_ready}, 128'd1);
`ifdef AES_ZEROISE_EN
        check_output("post_drain_ciphertext", bus.ciphertext, 128'd0);
`else
        check_output("post_drain_ciphertext", bus.ciphertext, C1_CT);
`endif

        run_aux();

        // Backpressure: sink stalls seven cycles, then drain and next accept share an edge
        bus.out_ready = 1'b0;
        k = rand128();
        p = rand128();
        e = ref_encrypt(k, p);
        apply_stimulus(k, p, e, 1'b0, acc);
        for (int n = 0; n < 40 && !bus.out_valid; n++) @(negedge clk);
        check_output("done_reached", {127'd0, bus.out_valid}, 128'd1);
        for (int n = 0; n < 7; n++) begin
            check_output("hold_ciphertext", bus.ciphertext, e);
            check_output("hold_in_ready", {127'd0, bus.in_ready}, 128'd0);
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.key       = rand128();
            bus.plaintext = rand128();
            @(negedge clk);
        end
        k = rand128();
        p = rand128();
        apply_stimulus(k, p, ref_encrypt(k, p), 1'b1, acc);
        @(negedge clk);
        check_output("same_edge_busy", {127'd0, bus.busy}, 128'd1);
        check_output("same_edge_out_valid", {127'd0, bus.out_valid}, 128'd0);
        wait_drain(40);

        // Streaming with the sink always ready
        prev_acc = 0;
        for (int b = 0; b < 8; b++) begin
            k = rand128();
            p = rand128();
            apply_stimulus(k, p, ref_encrypt(k, p), 1'b0, acc);
            if (b > 0) check_output("stream_period", 128'(acc - prev_acc), 128'(LAT + 1));
            prev_acc = acc;
        end
        wait_drain(40);

        // Reset around round 4 aborts the block
        k = rand128();
        p = rand128();
        apply_stimulus(k, p, ref_encrypt(k, p), 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_push -= sb_q.size();
        sb_q.delete();
        @(negedge clk);
        check_output("abort_in_ready", {127'd0, bus.in_ready}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check_output("abort_ciphertext", bus.ciphertext, 128'd0);
        check_output("abort_busy", {127'd0, bus.busy}, 128'd0);
        k = rand128();
        p = rand128();
        apply_stimulus(k, p, ref_encrypt(k, p), 1'b0, acc);
        wait_drain(40);

        check_output("queue_empty", 128'(sb_q.size()), 128'd0);
        check_output("output_count", 128'(n_out), 128'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got %0d outputs, required %0d", n_out, n_push);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
